// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S sample scheduler.
package i2s_pkg;
    localparam int FRAME_MCLKS = 256;
    localparam int PHASE_W     = 8;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;
endpackage

// File: rtl/sample_fifo.sv
// Circular buffer of stereo pairs with registered occupancy and a synchronous flush.
module sample_fifo import i2s_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    i_mclk,
    input  logic                    i_rst_x,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [2*SAMPLE_W-1:0]   i_wdata,
    output logic [2*SAMPLE_W-1:0]   o_rdata,
    output logic [AW:0]             o_level
);
    logic [2*SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   o_level <= o_level + 1'b1;
                2'b01:   o_level <= o_level - 1'b1;
                default: o_level <= o_level;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read once level says it was written.
    always_ff @(posedge i_mclk) begin
        if (i_push && !i_flush) mem[wr_ptr] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr];
endmodule

// File: rtl/i2s_sample_scheduler.sv
// Buffers upstream stereo pairs and presents one stable pair per 256-mclk frame to the
// I2S encoder, with priming, underrun handling, enable/disable and a status counter.
module i2s_sample_scheduler import i2s_pkg::*; #(
    parameter int DEPTH         = 4,
    parameter int PRIME         = 2,
    parameter bit UNDERRUN_ZERO = 1'b0,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                i_mclk,
    input  logic                i_rst_x,
    input  logic                i_enable,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SAMPLE_W-1:0] i_in_l,
    input  logic [SAMPLE_W-1:0] i_in_r,
    output logic [SAMPLE_W-1:0] o_data_l,
    output logic [SAMPLE_W-1:0] o_data_r,
    output logic                o_frame_start,
    output logic [LW-1:0]       o_level,
    output logic                o_running,
    output logic [7:0]          o_underrun_cnt,
    input  logic                i_clr_status,
    output logic [1:0]          o_dbg_state
);
    state_t                state;
    state_t                state_nxt;
    logic [PHASE_W-1:0]    phase;
    logic                  boundary;
    logic                  push;
    logic                  pop;
    logic                  underrun;
    logic                  flush;
    logic [2*SAMPLE_W-1:0] head;
    logic [LW-1:0]         level;

    // Handshake: a pair transfers on a rising edge where i_valid && o_ready; o_ready depends
    // only on registered state, and an unaccepted pair stays on i_in_* until it is taken.
    assign boundary = (phase == PHASE_W'(FRAME_MCLKS - 1));
    assign o_ready  = (state != i2s_pkg::STOP) && (level < LW'(DEPTH));
    assign push     = i_valid && o_ready;
    assign flush    = !i_enable || (state == i2s_pkg::STOP);

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_mclk  (i_mclk),
        .i_rst_x (i_rst_x),
        .i_flush (flush),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata ({i_in_l, i_in_r}),
        .o_rdata (head),
        .o_level (level)
    );

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) state <= i2s_pkg::STOP;
        else          state <= state_nxt;
    end

    // Pop decisions use the registered level, so a pair pushed on a boundary waits a frame.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        underrun  = 1'b0;
        if (!i_enable) begin
            state_nxt = i2s_pkg::STOP;
        end else begin
            case (state)
                i2s_pkg::STOP:  state_nxt = i2s_pkg::PRIME;
                i2s_pkg::PRIME: begin
                    if (boundary && (level >= LW'(PRIME))) begin
                        pop       = 1'b1;
                        state_nxt = i2s_pkg::RUN;
                    end
                end
                i2s_pkg::RUN: begin
                    if (boundary) begin
                        if (level != '0) pop = 1'b1;
                        else             underrun = 1'b1;
                    end
                end
                default: state_nxt = i2s_pkg::STOP;
            endcase
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            phase         <= '0;
            o_frame_start <= 1'b0;
        end else begin
            phase         <= phase + 1'b1;
            o_frame_start <= boundary;
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            o_data_l <= '0;
            o_data_r <= '0;
        end else if (!i_enable) begin
            o_data_l <= '0;
            o_data_r <= '0;
        end else if (pop) begin
            {o_data_l, o_data_r} <= head;
        end else if (underrun && UNDERRUN_ZERO) begin
            o_data_l <= '0;
            o_data_r <= '0;
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x)                              o_underrun_cnt <= '0;
        else if (i_clr_status)                     o_underrun_cnt <= '0;
        else if (underrun && (o_underrun_cnt != 8'hFF)) o_underrun_cnt <= o_underrun_cnt + 8'd1;
    end

    assign o_level     = level;
    assign o_running   = (state == i2s_pkg::RUN);
    assign o_dbg_state = state;
endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Bench for i2s_sample_scheduler: two instances (hold / zero on underrun) checked every
// cycle against a queue-based frame model, plus directed sequences for the corner cases.
module tb_i2s_sample_scheduler;
    import i2s_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PRIME_N = 2;
    localparam int S_STOP  = 0;
    localparam int S_PRIME = 1;
    localparam int S_RUN   = 2;

    logic        mclk = 1'b0;
    logic        rst_x = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;

    logic        ready0, ready1, fs0, fs1, run0, run1;
    logic [15:0] dl0, dr0, dl1, dr1;
    logic [2:0]  lvl0, lvl1;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  dbg0, dbg1;

    int n_vec = 0;
    int n_err = 0;

    always #5 mclk = ~mclk;

    i2s_sample_scheduler #(.DEPTH(DEPTH), .PRIME(PRIME_N), .UNDERRUN_ZERO(1'b0)) dut0 (
        .i_mclk(mclk), .i_rst_x(rst_x), .i_enable(enable), .i_valid(valid), .o_ready(ready0),
        .i_in_l(in_l), .i_in_r(in_r), .o_data_l(dl0), .o_data_r(dr0), .o_frame_start(fs0),
        .o_level(lvl0), .o_running(run0), .o_underrun_cnt(cnt0), .i_clr_status(clr),
        .o_dbg_state(dbg0)
    );

    i2s_sample_scheduler #(.DEPTH(DEPTH), .PRIME(PRIME_N), .UNDERRUN_ZERO(1'b1)) dut1 (
        .i_mclk(mclk), .i_rst_x(rst_x), .i_enable(enable), .i_valid(valid), .o_ready(ready1),
        .i_in_l(in_l), .i_in_r(in_r), .o_data_l(dl1), .o_data_r(dr1), .o_frame_start(fs1),
        .o_level(lvl1), .o_running(run1), .o_underrun_cnt(cnt1), .i_clr_status(clr),
        .o_dbg_state(dbg1)
    );

    // Frame-level reference: a queue of pairs, a mode, a frame position and held outputs.
    logic [31:0] m_q[$];
    int          m_phase;
    int          m_state;
    int          m_cnt;
    logic        m_fs;
    logic [15:0] m_l0, m_r0, m_l1, m_r1;

    task automatic model_reset();
        m_q.delete();
        m_phase = 0; m_state = S_STOP; m_cnt = 0; m_fs = 1'b0;
        m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0;
    endtask

    task automatic model_edge();
        logic        bnd;
        logic        rdy;
        logic        take;
        int          sz;
        logic [31:0] p;
        bnd  = (m_phase == 255);
        rdy  = (m_state != S_STOP) && (m_q.size() < DEPTH);
        take = valid && rdy;
        sz   = m_q.size();
        if (!enable) begin
            m_q.delete();
            m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0;
            m_state = S_STOP;
        end else begin
            if (bnd && ((m_state == S_PRIME && sz >= PRIME_N) || (m_state == S_RUN && sz > 0))) begin
                p = m_q.pop_front();
                {m_l0, m_r0} = p;
                {m_l1, m_r1} = p;
                m_state = S_RUN;
            end else if (bnd && m_state == S_RUN) begin
                m_l1 = '0; m_r1 = '0;
                if (m_cnt < 255) m_cnt++;
            end
            if (m_state == S_STOP) m_state = S_PRIME;
            if (take) m_q.push_back({in_l, in_r});
        end
        if (clr) m_cnt = 0;
        m_fs    = bnd;
        m_phase = (m_phase + 1) % 256;
    endtask

    function automatic logic [45:0] exp_bundle(input logic uz);
        logic rdy;
        rdy = (m_state != S_STOP) && (m_q.size() < DEPTH);
        if (uz) return {rdy, m_fs, 3'(m_q.size()), m_state == S_RUN, 8'(m_cnt), m_l1, m_r1};
        return {rdy, m_fs, 3'(m_q.size()), m_state == S_RUN, 8'(m_cnt), m_l0, m_r0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("dut0_outputs", {ready0, fs0, lvl0, run0, cnt0, dl0, dr0}, exp_bundle(1'b0));
        check("dut1_outputs", {ready1, fs1, lvl1, run1, cnt1, dl1, dr1}, exp_bundle(1'b1));
    endtask

    task automatic cycle();
        if (rst_x) model_edge();
        @(posedge mclk);
        #1;
        if (!rst_x) model_reset();
        compare_all();
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (m_phase == p) break;
        end
    endtask

    typedef struct {
        logic        valid;
        logic [15:0] l;
        logic [15:0] r;
        logic        exp_ready;
        logic [2:0]  exp_level;
    } vec_t;

    vec_t tab[7];
    int   thr_tab[4];
    int   thr;

    initial begin
        tab[0] = '{1'b1, 16'h1001, 16'h2001, 1'b1, 3'd1};
        tab[1] = '{1'b1, 16'h1002, 16'h2002, 1'b1, 3'd2};
        tab[2] = '{1'b1, 16'h1003, 16'h2003, 1'b1, 3'd3};
        tab[3] = '{1'b1, 16'h1004, 16'h2004, 1'b0, 3'd4};
        tab[4] = '{1'b1, 16'h1005, 16'h2005, 1'b0, 3'd4};
        tab[5] = '{1'b1, 16'h1006, 16'h2006, 1'b0, 3'd4};
        tab[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4};
        thr_tab = '{0, 2, 8, 64};

        // Reset and release
        #1;
        model_reset();
        compare_all();
        repeat (2) cycle();
        rst_x = 1'b1;
        #1;
        check("stop_ready_after_reset", ready0, 0);
        check("stop_state_after_reset", dbg0, 64'(STOP));

        // Priming: two pairs, first appears at the wrap, second one frame later
        enable = 1'b1;
        cycle();
        valid = 1'b1; in_l = 16'h1234; in_r = 16'hABCD;
        cycle();
        in_l = 16'h5555; in_r = 16'hAAAA;
        cycle();
        valid = 1'b0;
        check("prime_outputs_zero", {dl0, dr0}, 0);
        wait_phase(0);
        check("prime_first_l", dl0, 16'h1234);
        check("prime_first_r", dr0, 16'hABCD);
        check("prime_frame_start", fs0, 1);
        check("prime_running", run0, 1);
        wait_phase(0);
        check("prime_second_l", dl0, 16'h5555);
        check("prime_second_r", dr0, 16'hAAAA);

        // Randomized traffic with varying push rate, occasional clears and disables
        for (int f = 0; f < 8; f++) begin
            thr = thr_tab[$urandom_range(0, 3)];
            for (int c = 0; c < 256; c++) begin
                valid  = ($urandom_range(0, 255) < thr);
                in_l   = 16'($urandom);
                in_r   = 16'($urandom);
                clr    = ($urandom_range(0, 199) == 0);
                enable = ($urandom_range(0, 1499) != 0);
                cycle();
            end
        end
        valid = 1'b0; clr = 1'b0; enable = 1'b1;

        // Full FIFO while priming: six held cycles, four accepted
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        wait_phase(10);
        for (int i = 0; i < 7; i++) begin
            valid = tab[i].valid; in_l = tab[i].l; in_r = tab[i].r;
            cycle();
            check("full_ready", ready0, tab[i].exp_ready);
            check("full_level", lvl0, tab[i].exp_level);
        end
        valid = 1'b0;
        wait_phase(0);
        check("full_first_pop_l", dl0, 16'h1001);
        check("full_first_pop_r", dr0, 16'h2001);

        // Disable mid-frame with two pairs queued, then re-enable
        wait_phase(0);
        wait_phase(100);
        check("disable_level_before", lvl0, 2);
        enable = 1'b0;
        cycle();
        check("disable_running", run0, 0);
        check("disable_level", lvl0, 0);
        check("disable_data", {dl0, dr0, dl1, dr1}, 0);
        check("disable_ready", ready0, 0);
        enable = 1'b1;
        cycle();
        check("reenable_state", dbg0, 64'(PRIME));
        check("reenable_ready", ready0, 1);
        wait_phase(0);
        check("reenable_no_stale", {dl0, dr0, run0}, 0);

        // Underrun: hold vs zero, clear in the first underrun boundary, then saturate
        valid = 1'b1; in_l = 16'hC3C3; in_r = 16'h3C3C;
        cycle();
        in_l = 16'h0F0F; in_r = 16'hF0F0;
        cycle();
        valid = 1'b0;
        wait_phase(0);
        wait_phase(0);
        check("last_pair", {dl0, dr0}, 32'h0F0FF0F0);
        wait_phase(255);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_beats_increment", cnt0, 0);
        check("clr_beats_increment_z", cnt1, 0);
        check("underrun_hold", {dl0, dr0}, 32'h0F0FF0F0);
        check("underrun_zero", {dl1, dr1}, 0);
        for (int k = 1; k <= 256; k++) begin
            repeat (256) cycle();
            check("underrun_cnt", cnt0, (k > 255) ? 255 : k);
            check("underrun_cnt_z", cnt1, (k > 255) ? 255 : k);
            check("underrun_hold_frame", {dl0, dr0}, 32'h0F0FF0F0);
            check("underrun_zero_frame", {dl1, dr1}, 0);
        end

        // Asynchronous reset mid-frame with three pairs queued
        wait_phase(5);
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_l = 16'(16'h7000 + i); in_r = 16'(16'h8000 + i);
            cycle();
        end
        valid = 1'b0;
        wait_phase(50);
        check("reset_level_before", lvl0, 3);
        rst_x = 1'b0;
        #1;
        model_reset();
        check("reset_async_outputs", {dl0, dr0, fs0, lvl0, run0, ready0, cnt0}, 0);
        repeat (3) cycle();
        rst_x = 1'b1;
        #1;
        check("reset_release_state", dbg0, 64'(STOP));
        check("reset_release_ready", ready0, 0);
        repeat (300) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
